// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU micro-sequencer: opcodes, the ALU
// control word, the sequencer states and the per-opcode function table.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_OR  = 3'd0,
    OP_AND = 3'd1,
    OP_XOR = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4
  } alu_op_t;

  // Shifter control; the sequencer only ever passes data straight through.
  typedef enum logic [1:0] {
    NO_SH    = 2'd0,
    SH_LEFT  = 2'd1,
    SH_RIGHT = 2'd2
  } alu_sh_t;

  // Output-enable select: shifter path or result register onto the bus.
  typedef enum logic {
    SH_OE  = 1'b0,
    RES_OE = 1'b1
  } alu_oe_t;

  // Operand register load enable.
  typedef enum logic {
    NO_LD  = 1'b0,
    BUS_LD = 1'b1
  } alu_ld_t;

  // Function-select bits of one opcode, packed in r,s,v,ne,ci order.
  typedef struct packed {
    logic r;
    logic s;
    logic v;
    logic ne;
    logic ci;
  } alu_fn_t;

  typedef struct packed {
    logic [7:0] op;
    alu_sh_t    sh;
    alu_oe_t    oe;
    alu_ld_t    la;
    alu_ld_t    lb;
    logic       r;
    logic       s;
    logic       v;
    logic       ne;
    logic       ci;
    logic       l;
    logic       h;
  } alu_ctl_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDA  = 3'd1,
    ST_LDB  = 3'd2,
    ST_RES  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

  // Rows indexed by opcode. ADD shares the XOR select bits; the ALU's carry
  // chain turns it into a sum. Reserved opcodes decode to all-zero.
  localparam alu_fn_t FUNC_TBL [0:7] = '{
    5'b11100,  // OR
    5'b00100,  // AND
    5'b01100,  // XOR
    5'b01100,  // ADD
    5'b01111,  // SUB
    5'b00000,  // reserved
    5'b00000,  // reserved
    5'b00000   // reserved
  };

  function automatic logic op_is_valid(input alu_op_t op);
    return (op <= OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_dec.sv
// Control-word decoder: maps sequencer state plus the latched request onto
// the ALU control line. Purely combinational.
import alu_pkg::*;

module alu_seq_dec (
  input  seq_state_t state,
  input  alu_op_t    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output alu_ctl_t   ctl
);

  alu_fn_t fn;

  assign fn = FUNC_TBL[op];

  // Start from the quiescent word and override per active state.
  always_comb begin
    ctl    = '0;
    ctl.sh = NO_SH;
    ctl.oe = SH_OE;
    ctl.la = NO_LD;
    ctl.lb = NO_LD;
    case (state)
      ST_LDA: begin
        ctl.op = a;
        ctl.la = BUS_LD;
      end
      ST_LDB: begin
        ctl.op = b;
        ctl.lb = BUS_LD;
        {ctl.r, ctl.s, ctl.v, ctl.ne, ctl.ci} = fn;
        ctl.l  = 1'b1;
      end
      ST_RES: begin
        ctl.oe = RES_OE;
        {ctl.r, ctl.s, ctl.v, ctl.ne, ctl.ci} = fn;
        ctl.h  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// ALU micro-sequencer: accepts one operation request, walks the ALU through
// load-A, load-B and result cycles, then holds the captured result until the
// consumer takes it.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both 1. req_valid is ignored while busy, and
// rsp_* hold their value for as long as rsp_valid stays high.
import alu_pkg::*;

module alu_seq (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req_valid,
  output logic       req_ready,
  input  alu_op_t    req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output alu_ctl_t   ctl,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic       busy
);

  seq_state_t state;
  alu_op_t    op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // Sequencer state, request latch and response capture.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      op_q       <= OP_OR;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      rsp_result <= 8'h00;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            if (op_is_valid(req_op)) begin
              state <= ST_LDA;
            end else begin
              // Reserved opcode: answer immediately with an error response.
              state      <= ST_DONE;
              rsp_result <= 8'h00;
              rsp_zero   <= 1'b1;
              rsp_carry  <= 1'b0;
              rsp_err    <= 1'b1;
            end
          end
        end
        ST_LDA: state <= ST_LDB;
        ST_LDB: state <= ST_RES;
        ST_RES: begin
          // Only the result-cycle flags are meaningful.
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_carry  <= alu_carry;
          rsp_err    <= 1'b0;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  alu_seq_dec u_dec (
    .state (state),
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .ctl   (ctl)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a behavioural model of the request/response protocol and
// ALU arithmetic, a stand-in ALU that only presents the right answer in the
// result cycle, a per-cycle compare process, and directed vectors with
// hand-computed results.
import alu_pkg::*;

module tb_alu_seq;

  logic       clk;
  logic       nreset;
  logic       req_valid;
  logic       req_ready;
  alu_op_t    req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  alu_ctl_t   ctl;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_carry;
  logic       rsp_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit run_checks = 0;

  // Model: whether an operation is in flight, how many cycles since it was
  // accepted, whether its response is being offered, and the expected response.
  bit         m_busy = 0;
  bit         m_done = 0;
  int         m_age  = 0;
  logic [2:0] m_op   = 3'd0;
  logic [7:0] m_a    = 8'h00;
  logic [7:0] m_b    = 8'h00;
  logic [7:0] m_res  = 8'h00;
  logic       m_z    = 1'b0;
  logic       m_c    = 1'b0;
  logic       m_err  = 1'b0;

  alu_seq dut (
    .clk        (clk),
    .nreset     (nreset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .ctl        (ctl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // {carry, zero, result} of the ALU operation, from plain arithmetic.
  function automatic logic [9:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    s = 9'd0;
    r = 8'h00;
    c = 1'b0;
    case (op)
      3'd0: r = a | b;
      3'd1: r = a & b;
      3'd2: r = a ^ b;
      3'd3: begin s = {1'b0, a} + {1'b0, b}; {c, r} = s; end
      3'd4: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; {c, r} = s; end
      default: r = 8'h00;
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  // Function-select bits r,s,v,ne,ci per opcode.
  function automatic logic [4:0] exp_fn(input logic [2:0] op);
    case (op)
      3'd0:    return 5'b11100;
      3'd1:    return 5'b00100;
      3'd2:    return 5'b01100;
      3'd3:    return 5'b01100;
      3'd4:    return 5'b01111;
      default: return 5'b00000;
    endcase
  endfunction

  // Control word the ALU must see this cycle.
  function automatic alu_ctl_t exp_ctl();
    alu_ctl_t c;
    logic [4:0] f;
    c    = '0;
    c.sh = NO_SH;
    c.oe = SH_OE;
    c.la = NO_LD;
    c.lb = NO_LD;
    f    = exp_fn(m_op);
    if (m_busy && !m_done) begin
      if (m_age == 1) begin
        c.op = m_a;
        c.la = BUS_LD;
      end else if (m_age == 2) begin
        c.op = m_b;
        c.lb = BUS_LD;
        {c.r, c.s, c.v, c.ne, c.ci} = f;
        c.l = 1'b1;
      end else begin
        c.oe = RES_OE;
        {c.r, c.s, c.v, c.ne, c.ci} = f;
        c.h = 1'b1;
      end
    end
    return c;
  endfunction

  // ---------------- model ----------------
  initial begin
    logic [9:0] v;
    forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) begin
        m_busy = 0; m_done = 0; m_age = 0;
        m_res = 8'h00; m_z = 1'b0; m_c = 1'b0; m_err = 1'b0;
      end else if (!m_busy) begin
        if (req_valid) begin
          m_op = req_op; m_a = req_a; m_b = req_b;
          m_busy = 1; m_age = 1;
          if (3'(req_op) > 3'd4) begin
            m_done = 1;
            m_res = 8'h00; m_z = 1'b1; m_c = 1'b0; m_err = 1'b1;
          end
        end
      end else if (m_done) begin
        if (rsp_ready) begin m_busy = 0; m_done = 0; end
      end else if (m_age == 3) begin
        v = ref_alu(m_op, m_a, m_b);
        {m_c, m_z, m_res} = v;
        m_err  = 1'b0;
        m_done = 1;
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- compare + stand-in ALU ----------------
  initial begin
    alu_ctl_t   ec;
    logic [9:0] v;
    alu_result = 8'h00;
    alu_zero   = 1'b0;
    alu_carry  = 1'b0;
    forever begin
      @(negedge clk);
      if (run_checks) begin
        ec = exp_ctl();
        chk("ctl",        32'(ctl),        32'(ec));
        chk("req_ready",  32'(req_ready),  32'(!m_busy));
        chk("busy",       32'(busy),       32'(m_busy));
        chk("rsp_valid",  32'(rsp_valid),  32'(m_busy && m_done));
        chk("rsp_result", 32'(rsp_result), 32'(m_res));
        chk("rsp_zero",   32'(rsp_zero),   32'(m_z));
        chk("rsp_carry",  32'(rsp_carry),  32'(m_c));
        chk("rsp_err",    32'(rsp_err),    32'(m_err));
      end
      // Correct answer only in the result cycle, inverted garbage otherwise.
      v = ref_alu(m_op, m_a, m_b);
      if (m_busy && !m_done && m_age == 3) begin
        {alu_carry, alu_zero, alu_result} = v;
      end else begin
        {alu_carry, alu_zero, alu_result} = ~v;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 32'(req_ready), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ez, input logic ec, input logic ee,
                        input int lat, input int hold);
    int n;
    wait_idle();
    req_valid = 1'b1;
    req_op    = alu_op_t'(op);
    req_a     = a;
    req_b     = b;
    rsp_ready = (hold == 0);
    @(negedge clk);
    // Operands change after acceptance; the control word must not follow.
    req_valid = 1'b0;
    req_a     = 8'($urandom_range(0, 255));
    req_b     = 8'($urandom_range(0, 255));
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_result"},  32'(rsp_result), 32'(er));
    chk({name, "_zero"},    32'(rsp_zero),   32'(ez));
    chk({name, "_carry"},   32'(rsp_carry),  32'(ec));
    chk({name, "_err"},     32'(rsp_err),    32'(ee));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_op    = alu_op_t'($urandom_range(0, 4));
      req_a     = 8'($urandom_range(0, 255));
      req_b     = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk({name, "_hold_ready"},  32'(req_ready),  32'd0);
      chk({name, "_hold_valid"},  32'(rsp_valid),  32'd1);
      chk({name, "_hold_result"}, 32'(rsp_result), 32'(er));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({name, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nreset    = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_OR;
    req_a     = 8'h00;
    req_b     = 8'h00;
    rsp_ready = 1'b1;
    #2 nreset = 1'b0;
    run_checks = 1;
    #1;
    chk("rst_ctl",        32'(ctl),        32'd0);
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_zero",   32'(rsp_zero),   32'd0);
    chk("rst_rsp_err",    32'(rsp_err),    32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    //     name     op    a      b      result z     c     err   lat hold
    run_op("or",    3'd0, 8'h5A, 8'h0F, 8'h5F, 1'b0, 1'b0, 1'b0, 4, 0);
    run_op("and",   3'd1, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 4, 0);
    run_op("add",   3'd3, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 4, 0);
    run_op("xor",   3'd2, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 4, 0);
    run_op("sub1",  3'd4, 8'h30, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 4, 0);
    run_op("sub2",  3'd4, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0, 4, 0);
    run_op("sub3",  3'd4, 8'h42, 8'h42, 8'h00, 1'b1, 1'b1, 1'b0, 4, 0);
    run_op("rsv6",  3'd6, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b1, 1, 0);
    run_op("or2",   3'd0, 8'h81, 8'h42, 8'hC3, 1'b0, 1'b0, 1'b0, 4, 0);
    run_op("rsv7",  3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1, 0);
    run_op("hold",  3'd3, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 4, 10);

    // Reset pulse in the load-B cycle abandons the operation.
    wait_idle();
    req_valid = 1'b1;
    req_op    = OP_OR;
    req_a     = 8'h12;
    req_b     = 8'h34;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_lb", 32'(ctl.lb), 32'(BUS_LD));
    #2 nreset = 1'b0;
    #1;
    chk("mid_rst_ctl",   32'(ctl),       32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_op("or0",   3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 4, 0);

    repeat (3) @(negedge clk);
    run_checks = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
 clk  in  1  single clock; all state updates on rising edge.
 nreset  in  1  asynchronous, active-low reset.
 req_valid  in  1  operation request present.
 req_ready  out  1  sequencer can accept a request.
 req_op  in  alu_op_t (3)  operation code.
 req_a  in  8  first operand.
 req_b  in  8  second operand.
 ctl  out  alu_ctl_t  ALU control line: op, sh, oe, la, lb, r, s, v, ne, ci, l, h.
 alu_result  in  8  ALU result bus.
 alu_zero  in  1  ALU zero flag.
 alu_carry  in  1  ALU carry flag.
 rsp_valid  out  1  response available.
 rsp_ready  in  1  consumer accepts response.
 rsp_result  out  8  captured result.
 rsp_zero  out  1  captured zero flag.
 rsp_carry  out  1  captured carry flag.
 rsp_err  out  1  request carried a reserved opcode.
 busy  out  1  state != IDLE.

Function
REQ-002 Opcodes SHALL be OR=0, AND=1, XOR=2, ADD=3, SUB=4; 5-7 reserved.
REQ-003 States SHALL be IDLE, LDA, LDB, RES, DONE; ctl SHALL be decoded combinationally from state and latched request.
REQ-004 req_ready SHALL be 1 only in IDLE; handshake req_valid&req_ready latches op, a, b.
REQ-005 Accepted valid opcode: IDLE->LDA; reserved opcode: IDLE->DONE, rsp_err=1, rsp_result=0x00, rsp_zero=1, rsp_carry=0, no load cycles.
REQ-006 IDLE/DONE ctl: op=0x00, sh=NO_SH, oe=SH_OE, la=NO_LD, lb=NO_LD, r=s=v=ne=ci=l=h=0.
REQ-007 LDA ctl: op=a, sh=NO_SH, oe=SH_OE, la=BUS_LD, lb=NO_LD, function bits 0; next LDB.
REQ-008 LDB ctl: op=b, sh=NO_SH, oe=SH_OE, la=NO_LD, lb=BUS_LD, r/s/v/ne/ci from FUNC_TBL[op], l=1, h=0; next RES.
REQ-009 RES ctl: op=0x00, la=lb=NO_LD, oe=RES_OE, r/s/v/ne/ci from FUNC_TBL[op], l=0, h=1; on the RES edge capture alu_result, alu_zero, alu_carry into rsp_*, rsp_err=0; next DONE.
REQ-010 FUNC_TBL rows (r,s,v,ne,ci) SHALL be: OR 1,1,1,0,0; AND 0,0,1,0,0; XOR 0,1,1,0,0; ADD 0,1,1,0,0 with carry chain; SUB 0,1,1,1,1; exact row values live only in the package.
REQ-011 rsp_valid SHALL be 1 exactly in DONE; rsp_* SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-012 DONE with rsp_ready=1 SHALL go to IDLE next cycle; minimum spacing between accepted requests SHALL be 5 cycles.
REQ-013 For logical ops the LDB-cycle alu_carry is don't-care; only the RES-cycle sample is reported.
REQ-014 req_valid while busy SHALL be ignored without side effects; req_a/req_b changes after acceptance SHALL not affect ctl.

Reset
REQ-015 nreset low SHALL immediately force state IDLE, ctl to REQ-006 value, req_ready=1 after release, rsp_valid=0, rsp_result=0x00, rsp_zero=0, rsp_carry=0, rsp_err=0, busy=0.
REQ-016 Reset asserted in any state mid-operation SHALL abandon the operation; no response is produced for it.

Structure
REQ-017 Package alu_pkg SHALL hold alu_op_t, alu_ctl_t, NO_SH, SH_OE, RES_OE, BUS_LD, NO_LD, and FUNC_TBL.
REQ-018 One sub-module alu_seq_dec (state+op -> alu_ctl_t) SHALL be used; state register and response capture stay in alu_seq.

Verification
REQ-019 OR a=0x5A b=0x0F, rsp_ready=1 -> ctl matches LDA/LDB/RES in 3 consecutive cycles, rsp_result=0x5F, zero=0, carry=0, rsp_valid 4 cycles after acceptance.
REQ-020 AND a=0xF0 b=0x0F -> rsp_result=0x00, rsp_zero=1, rsp_carry=0.
REQ-021 ADD a=0xFF b=0x01 -> rsp_result=0x00, rsp_zero=1, rsp_carry=1.
REQ-022 Reserved op 6 -> rsp_valid next cycle, rsp_err=1, la/lb never BUS_LD.
REQ-023 rsp_ready=0 for 10 cycles in DONE, then 1 -> rsp_* stable, req_ready=0 throughout, IDLE one cycle after release.
REQ-024 nreset pulsed in LDB -> ctl idle immediately, no rsp_valid; next OR 0x00|0x00 -> result 0x00, zero=1.
